fcore_trace_buffer: RTL and testbench
=====================================

Name: fcore_trace_buffer

Overview:
Synthesizable on-chip capture stage that sits directly on the fCore instruction/DMA streams, in the same position as the simulation pipe tracer. It packs round-start, instruction-retire, round-finish and DMA-write events into tagged records and stores them in a circular BRAM FIFO. The FIFO drains over an AXI-stream master toward the host DMA path, so execution traces can be read back from hardware.

Parameters:
PC_WIDTH, 12, program-counter bits taken from instruction_stream.user
CHANNEL_WIDTH, 8, channel bits taken from instruction_stream.dest / dma_write.dest
DATA_WIDTH, 32, payload width
DEPTH, 1024, FIFO entries; power of two, at least 4

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  core round start pulse
done  in  1  core round done pulse
instruction_stream  axi_stream.slave  -  data = instruction, user = PC, dest = channel; monitor only, ready driven 1
dma_write  axi_stream.slave  -  data/dest of DMA register writes; monitor only, ready driven 1
trace_out  axi_stream.master  -  data = payload, user = {type[1:0], address}, tlast = end of round
clear_overflow  in  1  single-cycle clear of overflow and drop_count
overflow  out  1  sticky; set when a record is dropped
drop_count  out  16  saturating count of dropped records
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Address: address = {channel[CHANNEL_WIDTH-1:0], pc[PC_WIDTH-1:0]}, ADDR_W = PC_WIDTH + CHANNEL_WIDTH.
- Entry width: 2 + ADDR_W + DATA_WIDTH.
- Record types:
  - 0 START: payload = round counter.
  - 1 INSTR: payload = instruction word.
  - 2 FINISH: payload = instruction count for the round.
  - 3 DMA: payload = dma data; address = {dma dest, PC field 0}.
- FSM IDLE/RUNNING, reset to IDLE:
  - IDLE & start: push START, round_cnt++, instr_cnt <= 0, go to RUNNING.
  - RUNNING & done: push FINISH, go to IDLE.
  - start while RUNNING is ignored. done while IDLE is ignored.
- INSTR capture:
  - Registered prev_address, updated every cycle.
  - Push INSTR when cur_address != prev_address and FSM == RUNNING (the state value at that clock edge); instr_cnt++ on each push.
  - Capture on the START cycle itself is not done.
- DMA capture: push DMA on every cycle with dma_write.valid while FSM == IDLE. DMA writes while RUNNING are ignored.
- One push per cycle. Priority: INSTR > FINISH > START > DMA.
  - A displaced FINISH is held in a one-deep pending register and pushed on the next cycle, carrying the count that includes the coincident INSTR.
  - The FSM still leaves RUNNING on the done cycle.
  - A DMA displaced by a pending FINISH is dropped and counted as a drop.
- Full:
  - A push attempted while level == DEPTH is discarded.
  - overflow <= 1; drop_count increments and saturates at 0xFFFF.
  - FINISH is never reordered ahead of data.
- Output:
  - First-word-fall-through; trace_out.valid = !empty.
  - data/user/last are held stable while valid & !ready.
  - Pop on valid & ready. tlast = 1 only for FINISH records.
- Simultaneous push and pop when full: the pop frees space, so the push is accepted and level is unchanged.
- Pointers are ADDR $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are decided by MSB compare.
- clear_overflow in the same cycle as a drop: the drop wins, overflow stays 1 and drop_count = 1.
- Reset values:
  - FSM = IDLE; pointers = 0; level = 0.
  - trace_out.valid = 0, tlast = 0.
  - overflow = 0, drop_count = 0.
  - round_cnt = 0, instr_cnt = 0, pending = 0, prev_address = 0.
  - Reset mid-round discards all buffered records with no FINISH emitted.
- Latency: a record is visible on trace_out two cycles after its triggering edge (push register, then FIFO read).

Optional Feature:
FCORE_TRACE_TIMESTAMP_EN:
- Defined:
  - A 32-bit free-running cycle counter (reset to 0) is stored with every record.
  - It is driven on trace_out.dest, truncated to the interface dest width.
  - Entry width grows by 32.
- Not defined: trace_out.dest = 0 and no counter is instantiated.

Test Plan:
1. Reset, then start pulse and PC sequence 0x001, 0x002, 0x003 on channel 0 with data 0xA/0xB/0xC, then done → records START(payload 0), INSTR 0xA/0xB/0xC with addresses 0x001–0x003, FINISH(payload 3, tlast=1); a second round gives START payload 1.
2. Idle, dma_write valid for 2 cycles with data 0x1234 and 0x5678, dest 5 → two DMA records with user = {3, 5<<PC_WIDTH}. Same stimulus while RUNNING → no records.
3. PC change coincident with done → INSTR record first, then FINISH on the next cycle with count including that instruction.
4. DEPTH=4, trace_out.ready=0, push 6 records → level = 4, overflow = 1, drop_count = 2. Assert clear_overflow → both return to 0. Release ready → first 4 records appear in order.
5. Full FIFO with ready=1 and a push in the same cycle → push accepted, level stays 4. Hold ready low mid-stream → data stays stable.
6. Assert reset while RUNNING with 3 buffered records → valid = 0, level = 0 the next cycle. A subsequent done produces no record.

Source files
------------

// File: rtl/fcore_trace_buffer_if.sv
// fcore_trace_buffer_if: AXI-stream bundle carrying data, user, dest and tlast
interface fcore_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 12,
  parameter int DEST_W = 8
);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;
  logic [DEST_W-1:0] dest;
  logic tlast;
  modport master(output valid, data, user, dest, tlast, input ready);
  modport slave(input valid, data, user, dest, tlast, output ready);
endinterface

// File: rtl/fcore_trace_buffer.sv
// fcore_trace_buffer: tags fCore round/instr/DMA events into a circular FIFO drained over AXI-stream; FCORE_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp on trace_out.dest
module fcore_trace_buffer #(
  parameter int PC_WIDTH = 12,
  parameter int CHANNEL_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic done,
  fcore_trace_buffer_if.slave instruction_stream,
  fcore_trace_buffer_if.slave dma_write,
  fcore_trace_buffer_if.master trace_out,
  input  logic clear_overflow,
  output logic overflow,
  output logic [15:0] drop_count,
  output logic [$clog2(DEPTH):0] level
);
  localparam int ADDR_W = PC_WIDTH + CHANNEL_WIDTH;
  localparam int LW = $clog2(DEPTH);
  localparam int REC_W = 2 + ADDR_W + DATA_WIDTH;
`ifdef FCORE_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = REC_W + 32;
`else
  localparam int ENTRY_W = REC_W;
`endif
  localparam logic [1:0] T_START = 2'd0, T_INSTR = 2'd1, T_FINISH = 2'd2, T_DMA = 2'd3;
  typedef enum logic {IDLE, RUNNING} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] cur_addr, prev_addr, sel_a;
  logic [DATA_WIDTH-1:0] round_cnt, instr_cnt, sel_d;
  logic pending, instr_hit, fin_req, start_hit, dma_hit, sel_v;
  logic [1:0] sel_t, sel_drops, drop_inc;
  logic push_v;
  logic [ENTRY_W-1:0] push_e, entry, rd_e;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [LW:0] wptr, rptr;
  logic full, empty, pop, wr, fifo_drop;
  logic [16:0] drop_sum;
  logic unused_in;
  assign instruction_stream.ready = 1'b1;
  assign dma_write.ready = 1'b1;
  assign unused_in = ^{instruction_stream.valid, instruction_stream.tlast, dma_write.user, dma_write.tlast};
  always_comb begin
    cur_addr = {instruction_stream.dest, instruction_stream.user};
    instr_hit = state == RUNNING && cur_addr != prev_addr;
    fin_req = pending || (state == RUNNING && done);
    start_hit = state == IDLE && start;
    dma_hit = state == IDLE && dma_write.valid;
    sel_v = instr_hit || fin_req || start_hit || dma_hit;
    sel_t = instr_hit ? T_INSTR : fin_req ? T_FINISH : start_hit ? T_START : T_DMA;
    sel_a = instr_hit ? cur_addr : (fin_req || start_hit) ? '0 : {dma_write.dest, {PC_WIDTH{1'b0}}};
    sel_d = instr_hit ? instruction_stream.data : fin_req ? instr_cnt : start_hit ? round_cnt : dma_write.data;
    sel_drops = {1'b0, start_hit && pending} + {1'b0, dma_hit && (pending || start_hit)};
    state_d = state == IDLE ? (start ? RUNNING : IDLE) : (done ? IDLE : RUNNING);
  end
  assign full = wptr == {~rptr[LW], rptr[LW-1:0]};
  assign empty = wptr == rptr;
  assign pop = !empty && trace_out.ready;
  assign wr = push_v && (!full || pop);
  assign fifo_drop = push_v && full && !pop;
  assign level = wptr - rptr;
  assign drop_inc = sel_drops + {1'b0, fifo_drop};
  assign drop_sum = (clear_overflow ? 17'd0 : {1'b0, drop_count}) + {15'd0, drop_inc};
  assign rd_e = mem[rptr[LW-1:0]];
  assign trace_out.valid = !empty;
  assign trace_out.data = rd_e[DATA_WIDTH-1:0];
  assign trace_out.user = rd_e[REC_W-1:DATA_WIDTH];
  assign trace_out.tlast = !empty && rd_e[REC_W-1 -: 2] == T_FINISH;
`ifdef FCORE_TRACE_TIMESTAMP_EN
  localparam int TDW = $bits(trace_out.dest);
  logic [31:0] ts;
  always_ff @(posedge clock) ts <= reset ? 32'd0 : ts + 32'd1;
  assign entry = {ts, sel_t, sel_a, sel_d};
  assign trace_out.dest = rd_e[REC_W +: TDW];
`else
  assign entry = {sel_t, sel_a, sel_d};
  assign trace_out.dest = '0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      prev_addr <= '0;
      round_cnt <= '0;
      instr_cnt <= '0;
      pending <= 1'b0;
      push_v <= 1'b0;
      push_e <= '0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_d;
      prev_addr <= cur_addr;
      round_cnt <= start_hit ? round_cnt + DATA_WIDTH'(1) : round_cnt;
      instr_cnt <= start_hit ? '0 : instr_hit ? instr_cnt + DATA_WIDTH'(1) : instr_cnt;
      pending <= instr_hit && done;
      push_v <= sel_v;
      push_e <= entry;
      wptr <= wptr + (LW+1)'(wr);
      rptr <= rptr + (LW+1)'(pop);
      overflow <= drop_inc != 2'd0 ? 1'b1 : clear_overflow ? 1'b0 : overflow;
      drop_count <= (drop_inc != 2'd0 || clear_overflow) ? (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]) : drop_count;
    end
  end
  always_ff @(posedge clock) if (wr) mem[wptr[LW-1:0]] <= push_e;
endmodule

// File: tb/tb_fcore_trace_buffer.sv
// tb_fcore_trace_buffer: directed checks of record stream, FIFO full handling and reset
module tb_fcore_trace_buffer;
  localparam int PW = 12, CW = 8, DW = 32, DEPTH = 4, AW = PW + CW, UW = 2 + AW, LW = $clog2(DEPTH);
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, done = 1'b0, clear_overflow = 1'b0;
  logic overflow;
  logic [15:0] drop_count;
  logic [LW:0] level;
  int total = 0, bad = 0;
  logic [54:0] log_q [$];
  fcore_trace_buffer_if #(.DATA_W(DW), .USER_W(PW), .DEST_W(CW)) istr();
  fcore_trace_buffer_if #(.DATA_W(DW), .USER_W(PW), .DEST_W(CW)) dma();
  fcore_trace_buffer_if #(.DATA_W(DW), .USER_W(UW), .DEST_W(8)) tro();
  fcore_trace_buffer #(.PC_WIDTH(PW), .CHANNEL_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .instruction_stream(istr), .dma_write(dma), .trace_out(tro),
    .clear_overflow(clear_overflow), .overflow(overflow), .drop_count(drop_count), .level(level)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (tro.valid === 1'b1 && tro.ready === 1'b1) log_q.push_back({tro.tlast, tro.user, tro.data});
  function automatic logic [54:0] rec(input logic l, input logic [1:0] t, input logic [AW-1:0] a, input logic [31:0] d);
    return {l, t, a, d};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    total += 5;
    if (tro.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tro.valid); end
    if (tro.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", tro.tlast); end
    if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    total++;
    if (istr.ready !== 1'b1 || dma.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b exp=11", istr.ready, dma.ready); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_round;
    logic [54:0] want [$];
    logic [54:0] got;
    log_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    istr.user = 12'h001; istr.data = 32'hA; tick();
    istr.user = 12'h002; istr.data = 32'hB; tick();
    istr.user = 12'h003; istr.data = 32'hC; tick();
    done = 1'b1; tick(); done = 1'b0;
    tick(8);
    want = '{rec(0, 0, 0, 0), rec(0, 1, 20'h00001, 32'hA), rec(0, 1, 20'h00002, 32'hB), rec(0, 1, 20'h00003, 32'hC), rec(1, 2, 0, 3)};
    start = 1'b1; tick(); start = 1'b0; tick();
    done = 1'b1; tick(); done = 1'b0;
    tick(8);
    want.push_back(rec(0, 0, 0, 1));
    want.push_back(rec(1, 2, 0, 0));
    total++;
    if (log_q.size() != want.size()) begin bad++; $display("FAIL round_count got=%0d exp=%0d", log_q.size(), want.size()); end
    for (int i = 0; i < want.size(); i++) begin
      total++;
      got = (i < log_q.size()) ? log_q[i] : 'x;
      if (got !== want[i]) begin bad++; $display("FAIL round_rec%0d got=%h exp=%h", i, got, want[i]); end
    end
  endtask
  task automatic test_dma;
    logic [54:0] want [$];
    logic [54:0] got;
    log_q.delete();
    dma.dest = 8'd5; dma.valid = 1'b1; dma.data = 32'h1234; tick();
    dma.data = 32'h5678; tick();
    dma.valid = 1'b0; tick(6);
    want = '{rec(0, 3, 20'h05000, 32'h1234), rec(0, 3, 20'h05000, 32'h5678)};
    start = 1'b1; tick(); start = 1'b0; tick();
    dma.valid = 1'b1; dma.data = 32'h1234; tick();
    dma.data = 32'h5678; tick();
    dma.valid = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    tick(8);
    want.push_back(rec(0, 0, 0, 2));
    want.push_back(rec(1, 2, 0, 0));
    total++;
    if (log_q.size() != want.size()) begin bad++; $display("FAIL dma_count got=%0d exp=%0d", log_q.size(), want.size()); end
    for (int i = 0; i < want.size(); i++) begin
      total++;
      got = (i < log_q.size()) ? log_q[i] : 'x;
      if (got !== want[i]) begin bad++; $display("FAIL dma_rec%0d got=%h exp=%h", i, got, want[i]); end
    end
    total++;
    if (drop_count !== 16'd0) begin bad++; $display("FAIL dma_running_drop got=%0d exp=0", drop_count); end
  endtask
  task automatic test_done_coincident;
    logic [54:0] want [$];
    logic [54:0] got;
    log_q.delete();
    start = 1'b1; tick(); start = 1'b0; tick();
    istr.user = 12'h010; istr.data = 32'h55; done = 1'b1; tick(); done = 1'b0;
    tick(8);
    want = '{rec(0, 0, 0, 3), rec(0, 1, 20'h00010, 32'h55), rec(1, 2, 0, 1)};
    total++;
    if (log_q.size() != want.size()) begin bad++; $display("FAIL coinc_count got=%0d exp=%0d", log_q.size(), want.size()); end
    for (int i = 0; i < want.size(); i++) begin
      total++;
      got = (i < log_q.size()) ? log_q[i] : 'x;
      if (got !== want[i]) begin bad++; $display("FAIL coinc_rec%0d got=%h exp=%h", i, got, want[i]); end
    end
  endtask
  task automatic test_overflow;
    logic [54:0] got;
    log_q.delete();
    tro.ready = 1'b0;
    dma.dest = 8'd1; dma.valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      dma.data = i;
      tick();
    end
    dma.valid = 1'b0; tick(4);
    total += 4;
    if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drops got=%0d exp=2", drop_count); end
    if (tro.valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", tro.valid); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clr_flag got=%b exp=0", overflow); end
    if (drop_count !== 16'd0) begin bad++; $display("FAIL clr_drops got=%0d exp=0", drop_count); end
    dma.valid = 1'b1; dma.data = 32'd7; tick();
    dma.valid = 1'b0; clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL clrdrop_flag got=%b exp=1", overflow); end
    if (drop_count !== 16'd1) begin bad++; $display("FAIL clrdrop_drops got=%0d exp=1", drop_count); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    tro.ready = 1'b1; tick(8);
    total++;
    if (log_q.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      got = (i < log_q.size()) ? log_q[i] : 'x;
      if (got !== rec(0, 3, 20'h01000, i + 1)) begin bad++; $display("FAIL ovf_rec%0d got=%h exp=%h", i, got, rec(0, 3, 20'h01000, i + 1)); end
    end
  endtask
  task automatic test_full_pop_push;
    logic [54:0] got;
    log_q.delete();
    tro.ready = 1'b0;
    dma.dest = 8'd1; dma.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dma.data = 32'h10 + i;
      tick();
    end
    dma.valid = 1'b0; tick(3);
    total++;
    if (level !== 3'd4) begin bad++; $display("FAIL fpp_fill got=%0d exp=4", level); end
    dma.valid = 1'b1; dma.data = 32'h14; tick();
    dma.valid = 1'b0; tro.ready = 1'b1; tick(); tro.ready = 1'b0;
    total += 3;
    if (level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d exp=4", level); end
    if (drop_count !== 16'd0) begin bad++; $display("FAIL fpp_drops got=%0d exp=0", drop_count); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_flag got=%b exp=0", overflow); end
    total++;
    if (tro.data !== 32'h11) begin bad++; $display("FAIL hold_data0 got=%h exp=11", tro.data); end
    tick(3);
    total += 3;
    if (tro.data !== 32'h11) begin bad++; $display("FAIL hold_data got=%h exp=11", tro.data); end
    if (tro.user !== 22'h301000) begin bad++; $display("FAIL hold_user got=%h exp=301000", tro.user); end
    if (tro.valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", tro.valid); end
    tro.ready = 1'b1; tick(8);
    total++;
    if (log_q.size() != 5) begin bad++; $display("FAIL fpp_count got=%0d exp=5", log_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      got = (i < log_q.size()) ? log_q[i] : 'x;
      if (got !== rec(0, 3, 20'h01000, 32'h10 + i)) begin bad++; $display("FAIL fpp_rec%0d got=%h exp=%h", i, got, rec(0, 3, 20'h01000, 32'h10 + i)); end
    end
  endtask
  task automatic test_reset_mid;
    log_q.delete();
    tro.ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    istr.user = 12'h020; tick();
    istr.user = 12'h021; tick();
    tick(3);
    total++;
    if (level !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d exp=3", level); end
    reset = 1'b1; tick(); reset = 1'b0;
    total += 2;
    if (tro.valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", tro.valid); end
    if (level !== 3'd0) begin bad++; $display("FAIL mid_level0 got=%0d exp=0", level); end
    done = 1'b1; tick(); done = 1'b0;
    tro.ready = 1'b1; tick(6);
    total += 2;
    if (log_q.size() != 0) begin bad++; $display("FAIL mid_records got=%0d exp=0", log_q.size()); end
    if (level !== 3'd0) begin bad++; $display("FAIL mid_after got=%0d exp=0", level); end
  endtask
  initial begin
    istr.valid = 1'b0; istr.data = '0; istr.user = '0; istr.dest = '0; istr.tlast = 1'b0;
    dma.valid = 1'b0; dma.data = '0; dma.user = '0; dma.dest = '0; dma.tlast = 1'b0;
    tro.ready = 1'b1;
    test_reset();
    test_round();
    test_dma();
    test_done_coincident();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
